// File: rtl/ps2_keyboard_interface_pkg.sv
// Shared constants and receiver state encoding for the PS/2 keyboard front end.
`timescale 1ns/1ps
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  typedef logic [0:0] rx_state_t;
  localparam rx_state_t IDLE      = 1'b0;
  localparam rx_state_t RECEIVING = 1'b1;

endpackage

// File: rtl/ps2_keyboard_interface_line_filter.sv
// Synchroniser plus level debounce for a slow external line; emits a one-cycle
// pulse when the debounced level falls.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_line,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_count;
  logic                   r_level;
  logic                   r_fall;
  logic                   w_sample;
  logic                   w_settle;

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign w_settle = (r_count == CW'(FILTER_CYCLES - 1));
  assign o_fall   = r_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(i_line);
    end
  end

  // The level only follows the line once it has disagreed for FILTER_CYCLES samples in a row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_sample == r_level) begin
        r_count <= '0;
      end else if (w_settle) begin
        r_count <= '0;
        r_level <= w_sample;
        r_fall  <= ~w_sample;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_interface.sv
// Receive-only PS/2 keyboard front end: deserialises frames and tracks the held key.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
`timescale 1ns/1ps
module ps2_keyboard_interface
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_dataSync;
  rx_state_t              r_state;
  logic [3:0]             r_bitCount;
  logic [8:0]             r_shift;
  logic [TW-1:0]          r_idleCount;
  logic                   r_breakFlag;
  logic                   w_fall;
  logic                   w_data;
  logic                   w_parityOk;
  logic [7:0]             w_byte;

  ps2_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clockFilter (
    .clock (clock),
    .reset (reset),
    .i_line(ps2_clock),
    .o_fall(w_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dataSync <= '1;
    end else begin
      r_dataSync <= (r_dataSync << 1) | SYNC_STAGES'(ps2_data);
    end
  end

  assign w_data = r_dataSync[SYNC_STAGES-1];
  assign w_byte = r_shift[7:0];

`ifdef PS2_PARITY_CHECK_EN
  assign w_parityOk = ^r_shift;
`else
  assign w_parityOk = 1'b1;
`endif

  // Data and parity bits shift in from the top, so after bit 9 r_shift = {parity, byte}.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_bitCount      <= '0;
      r_shift         <= '0;
      r_idleCount     <= '0;
      r_breakFlag     <= 1'b0;
      ps2_key_data    <= '0;
      ps2_key_pressed <= 1'b0;
      ps2_out         <= '0;
    end else begin
      ps2_key_pressed <= 1'b0;
      if (r_state == IDLE) begin
        r_idleCount <= '0;
        if (w_fall && !w_data) begin
          r_state    <= RECEIVING;
          r_bitCount <= 4'd1;
        end
      end else if (w_fall) begin
        r_idleCount <= '0;
        if (r_bitCount == 4'(FRAME_BITS - 1)) begin
          r_state    <= IDLE;
          r_bitCount <= '0;
          if (w_data && w_parityOk) begin
            ps2_key_data    <= w_byte;
            ps2_key_pressed <= 1'b1;
            if (w_byte == BREAK_CODE) begin
              r_breakFlag <= 1'b1;
            end else if (r_breakFlag) begin
              r_breakFlag <= 1'b0;
              if (w_byte == ps2_out) begin
                ps2_out <= '0;
              end
            end else if (w_byte != EXT_CODE) begin
              ps2_out <= w_byte;
            end
          end
        end else begin
          r_shift    <= {w_data, r_shift[8:1]};
          r_bitCount <= r_bitCount + 4'd1;
        end
      end else if (r_idleCount == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state     <= IDLE;
        r_bitCount  <= '0;
        r_idleCount <= '0;
      end else begin
        r_idleCount <= r_idleCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_interface.sv
// Directed bench for the PS/2 keyboard front end with a byte scoreboard on the strobe.
`timescale 1ns/1ps
module tb_ps2_keyboard_interface;

  localparam int QTR_NS  = 200;
  localparam int HALF_NS = 400;
  localparam int TIMEOUT = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2ClockDrv = 1'b1;
  logic       ps2DataDrv = 1'b1;
  wire        ps2ClockLine;
  wire        ps2DataLine;
  logic [7:0] ps2KeyData;
  logic       ps2KeyPressed;
  logic [7:0] ps2Out;
  int         total = 0;
  int         bad = 0;
  logic [7:0] expQ[$];
  logic       prevStrobe = 1'b0;

  assign ps2ClockLine = ps2ClockDrv;
  assign ps2DataLine  = ps2DataDrv;

  always #5 clock = ~clock;

  ps2_keyboard_interface #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clock      (ps2ClockLine),
    .ps2_data       (ps2DataLine),
    .ps2_key_data   (ps2KeyData),
    .ps2_key_pressed(ps2KeyPressed),
    .ps2_out        (ps2Out)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic value);
    ps2DataDrv = value;
    #(QTR_NS);
    ps2ClockDrv = 1'b0;
    #(HALF_NS);
    ps2ClockDrv = 1'b1;
    #(QTR_NS);
  endtask

  // Device-to-host frame, LSB first; expectValid queues the byte for the scoreboard.
  task automatic applyStimulus(input logic [7:0] value, input logic badParity, input logic startBit,
                               input logic stopBit, input int nBits, input logic expectValid);
    logic [10:0] frame;
    frame = {stopBit, (~^value) ^ badParity, value, startBit};
    if (expectValid) expQ.push_back(value);
    for (int i = 0; i < nBits; i++) sendBit(frame[i]);
    ps2DataDrv = 1'b1;
    @(negedge clock);
  endtask

  // Scoreboard: each strobe must be one cycle wide and carry the next queued byte.
  initial begin
    forever begin
      @(negedge clock);
      if (ps2KeyPressed) begin
        total++;
        assert (!prevStrobe) else begin
          bad++;
          $error("FAIL strobeWidth observed=2+ cycles expected=1 cycle");
        end
        total++;
        assert (expQ.size() > 0) else begin
          bad++;
          $error("FAIL unexpectedStrobe observed=%02h expected=none", ps2KeyData);
        end
        if (expQ.size() > 0) checkOutput("keyData", ps2KeyData, expQ.pop_front());
      end
      prevStrobe = ps2KeyPressed;
    end
  end

  initial begin
    repeat (4) @(negedge clock);
    checkOutput("resetKeyData", ps2KeyData, 8'h00);
    checkOutput("resetPressed", {7'd0, ps2KeyPressed}, 8'h00);
    checkOutput("resetOut", ps2Out, 8'h00);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("makeOut", ps2Out, 8'h1C);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("breakPrefixOut", ps2Out, 8'h1C);
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("releaseOut", ps2Out, 8'h00);

    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    applyStimulus(8'h32, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("secondKeyOut", ps2Out, 8'h32);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("otherReleaseOut", ps2Out, 8'h32);
    applyStimulus(8'hE0, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("extPrefixOut", ps2Out, 8'h32);
    applyStimulus(8'h4D, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("newKeyOut", ps2Out, 8'h4D);

`ifdef PS2_PARITY_CHECK_EN
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b1, 11, 1'b0);
    checkOutput("badParityKeyData", ps2KeyData, 8'h4D);
    checkOutput("badParityOut", ps2Out, 8'h4D);
`else
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("badParityKeyData", ps2KeyData, 8'h1C);
    checkOutput("badParityOut", ps2Out, 8'h1C);
`endif

    applyStimulus(8'h77, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    repeat (2 * TIMEOUT) @(negedge clock);
    applyStimulus(8'h29, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("afterTimeoutKeyData", ps2KeyData, 8'h29);
    checkOutput("afterTimeoutOut", ps2Out, 8'h29);

    ps2DataDrv = 1'b0;
    ps2ClockDrv = 1'b0;
    #40;
    ps2ClockDrv = 1'b1;
    #(QTR_NS);
    ps2DataDrv = 1'b1;
    repeat (100) @(negedge clock);
    applyStimulus(8'h16, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("afterGlitchOut", ps2Out, 8'h16);

    applyStimulus(8'h3A, 1'b0, 1'b0, 1'b1, 6, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("midResetKeyData", ps2KeyData, 8'h00);
    checkOutput("midResetPressed", {7'd0, ps2KeyPressed}, 8'h00);
    checkOutput("midResetOut", ps2Out, 8'h00);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    applyStimulus(8'h45, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("postResetOut", ps2Out, 8'h45);

    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0, 11, 1'b0);
    repeat (2 * TIMEOUT) @(negedge clock);
    checkOutput("badStopKeyData", ps2KeyData, 8'h45);
    checkOutput("badStopOut", ps2Out, 8'h45);
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1, 11, 1'b0);
    repeat (2 * TIMEOUT) @(negedge clock);
    checkOutput("badStartKeyData", ps2KeyData, 8'h45);
    checkOutput("badStartOut", ps2Out, 8'h45);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    checkOutput("recoveryOut", ps2Out, 8'h5A);

    repeat (50) @(negedge clock);
    checkOutput("queueDrained", 8'(expQ.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
